// File: rtl/count19_pkg.sv
// Shared state encodings and display constants for the 0-19 counter run controller.
package count19_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t RUN   = 2'b01;
  localparam state_t PAUSE = 2'b10;

  localparam logic [1:0] DIG_ONES  = 2'b01;
  localparam logic [1:0] DIG_TENS  = 2'b10;
  localparam logic [1:0] DIG_OFF   = 2'b00;
  localparam logic [3:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge pulse for one debounced button level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, s3;
  logic v1, v2;
  logic armed;

  // Edges are only reported once a genuine released level has been seen after
  // reset, so a button held through reset stays silent until pressed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
      v1 <= 1'b1;
      v2 <= v1;
      if (v2 && !s2) armed <= 1'b1;
    end
  end

  assign pulse = armed & s2 & ~s3;

endmodule

// File: rtl/count19_ctrl.sv
// Run controller for the 0..MAX_COUNT counter: IDLE/RUN/PAUSE sequencing and digit scan.
// Optional BLANK_LEAD_ZERO_EN blanks the tens digit when it is zero.
module count19_ctrl
  import count19_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int MAX_COUNT = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic [4:0] bin,
  output logic       running,
  output logic       wrap,
  output logic [1:0] dig_sel,
  output logic [3:0] scan_bcd
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [4:0]    CNT_MAX   = 5'(MAX_COUNT);

  logic start_p, pause_p, clr_p;

  btn_edge u_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p));
  btn_edge u_pause (.clk(clk), .rst_n(rst_n), .btn(btn_pause), .pulse(pause_p));
  btn_edge u_clear (.clk(clk), .rst_n(rst_n), .btn(btn_clear), .pulse(clr_p));

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [4:0]    count;

  // An accepted pause leaves tick_cnt untouched, even at its terminal value,
  // so the pending step fires on the first cycle after resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      count    <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        state    <= IDLE;
        tick_cnt <= '0;
        count    <= '0;
      end else begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            count    <= '0;
            if (start_p) state <= RUN;
          end
          RUN: begin
            if (pause_p) begin
              state <= PAUSE;
            end else if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (count == CNT_MAX) begin
                count <= '0;
                wrap  <= 1'b1;
              end else begin
                count <= count + 5'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          PAUSE: begin
            if (start_p || pause_p) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bin     = count;
  assign running = (state == RUN);

  logic [SW-1:0] scan_cnt;
  logic          slot_tens;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      slot_tens <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      slot_tens <= ~slot_tens;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  always_comb begin
    dig_sel  = slot_tens ? DIG_TENS : DIG_ONES;
    scan_bcd = slot_tens ? bcd_tens : bcd_ones;
`ifdef BLANK_LEAD_ZERO_EN
    if (slot_tens && (bcd_tens == 4'd0)) begin
      dig_sel  = DIG_OFF;
      scan_bcd = BCD_BLANK;
    end
`endif
  end

endmodule

// File: doc/count19_ctrl.md
# count19_ctrl

Run controller for the 0–19 counter lab design. Owns the count register, sequences it through IDLE/RUN/PAUSE from three debounced buttons, drives the binary value into the binary-to-BCD converter (binary_bcd), and time-multiplexes the returned tens/ones digits onto a single 7-segment decoder path. Sits between the button debouncers and the display decoder at the top level.

## Interface
- TICK_DIV, 50_000_000, clock cycles per count step (≥2)
- SCAN_DIV, 50_000, clock cycles per digit-scan slot (≥2)
- MAX_COUNT, 19, terminal count before wrap to 0 (1..31)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- btn_start  in  1  debounced level, asynchronous to clk
- btn_pause  in  1  debounced level, asynchronous to clk
- btn_clear  in  1  debounced level, asynchronous to clk
- bcd_tens  in  4  tens digit returned by binary_bcd
- bcd_ones  in  4  ones digit returned by binary_bcd
- bin  out  5  registered count, to binary_bcd
- running  out  1  high while in RUN
- wrap  out  1  one-cycle pulse on MAX_COUNT→0
- dig_sel  out  2  one-hot digit enable, active-high: 01 ones, 10 tens
- scan_bcd  out  4  BCD digit for the selected position

## Operation
- Reset values: bin=0, running=0, wrap=0, dig_sel=01, state IDLE, both prescalers 0. scan_bcd follows the combinational mux.
- Each button: two-flop synchronizer, then rising-edge detect. One press produces one action regardless of hold length.
- States:
  - IDLE: count held at 0, tick prescaler held at 0.
  - RUN: tick prescaler counts 0..TICK_DIV-1. On terminal value it returns to 0 and the count steps.
  - PAUSE: count and tick prescaler frozen at their current values.
- Transitions:
  - IDLE –start→ RUN.
  - RUN –pause→ PAUSE.
  - PAUSE –start or pause→ RUN, resuming from the frozen prescaler value.
  - Any state –clear→ IDLE with count=0 and prescaler=0.
  - start in RUN is ignored. pause in IDLE is ignored.
- Priority for same-cycle edges: clear > start > pause.
- Count step: count<MAX_COUNT → +1. count==MAX_COUNT → 0, with wrap=1 in the same cycle that bin reads 0.
- Tick coincident with clear: clear wins, bin=0, wrap=0.
- Tick coincident with an accepted pause: no step; the prescaler holds at its terminal value, so the step occurs on the first cycle after resume.
- Scan: the scan prescaler runs continuously in every state. Every SCAN_DIV cycles dig_sel toggles 01↔10. scan_bcd = (dig_sel==10) ? bcd_tens : bcd_ones.
- Widths: prescalers are $clog2(TICK_DIV) and $clog2(SCAN_DIV) bits. The count is 5 bits unsigned with no overflow beyond MAX_COUNT.

## Timing
- Button rising before clk edge N: synchronizer output high after N+1, edge pulse valid during N+1..N+2, state/count update at edge N+2. running is visible after edge N+2.
- From entering RUN, the first count step occurs TICK_DIV cycles later. The steady-state period is TICK_DIV cycles.
- bin is registered and changes only on a step or clear. binary_bcd is combinational, so scan_bcd reflects a new bin in the same cycle.
- dig_sel period = 2·SCAN_DIV cycles with a 50% duty cycle per digit.
- Reset asserted mid-RUN: all outputs return to their reset values immediately (asynchronously). Operation restarts in IDLE on the first edge after deassertion. Synchronizer flops are cleared, so a button held through reset generates no edge until it is released and pressed again.

## Configuration
- BLANK_LEAD_ZERO_EN defined: during the tens slot, if bcd_tens==0, dig_sel=00 and scan_bcd=4'hF (both off). Slot timing is unchanged.
- BLANK_LEAD_ZERO_EN undefined: the tens digit is always shown, including 0.

## Structure
- Package count19_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.
  - constants DIG_ONES=2'b01, DIG_TENS=2'b10, DIG_OFF=2'b00, BCD_BLANK=4'hF.
- Sub-module btn_edge (synchronizer + rising-edge pulse), instantiated three times.
- binary_bcd is instantiated at the top level beside this block, not inside it.

## Test plan
Run with TICK_DIV=4, SCAN_DIV=3.
- Reset, then start pulse → running=1 two edges after the synchronized press. bin steps 0→1 four cycles after RUN is entered, then every 4 cycles.
- RUN from 0 for 20 steps → bin reaches 19, then 0 with wrap=1 for exactly one cycle. No wrap on any other step.
- Pause at bin=7, hold 20 cycles, then start → bin stays 7 throughout PAUSE and steps to 8 after the remaining prescaler cycles.
- start and clear asserted in the same cycle while in RUN at bin=12 → IDLE, bin=0, running=0, wrap=0.
- bin=5 (tens 0, ones 5) → dig_sel alternates 01/10 every 3 cycles and scan_bcd alternates 5/0. With BLANK_LEAD_ZERO_EN, the tens slot shows dig_sel=00 and scan_bcd=F.
- rst_n low for 1 cycle mid-RUN at bin=15 while btn_start is held → bin=0 and dig_sel=01 immediately. The block stays in IDLE until btn_start is released and pressed again.
